fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage sitting directly upstream of `instruction_memory`. It owns the program counter and drives the memory's byte address. It captures the 32-bit word the memory returns combinationally in the same cycle, and buffers up to two fetched {pc, instruction} pairs in a small queue. Decode consumes those pairs over a valid/ready handshake, and branch/jump redirects, back-pressure and fetch faults are all handled here.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of PC and memory byte address
- `INSTR_WIDTH`, 32, instruction word width; always 4 × 8-bit bytes
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `IMEM_BYTES`, 91, memory depth in bytes; highest legal word start is `IMEM_BYTES-4`

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `imem_addr`  out  ADDR_WIDTH  byte address to instruction memory; equals `pc`
- `imem_data`  in  INSTR_WIDTH  word returned by memory for `imem_addr`, valid in the same cycle
- `redirect`  in  1  taken branch/jump from execute
- `redirect_pc`  in  ADDR_WIDTH  redirect target
- `out_valid`  out  1  queue head holds an instruction
- `out_ready`  in  1  decode accepts the head this cycle
- `out_pc`  out  ADDR_WIDTH  PC of head instruction
- `out_instr`  out  INSTR_WIDTH  head instruction word, unmodified from `imem_data`
- `fault`  out  1  fetch halted on out-of-range PC or misaligned redirect
- `fault_addr`  out  ADDR_WIDTH  offending PC/target; 0 when `fault`=0

## Operation
- State machine, two states:
  - FETCH: normal fetching.
  - HALT: PC frozen, no pushes. HALT is left only via `redirect` to a legal target, or via `rst`.
- Queue: 2 entries of {pc, instr}, with `count` ∈ {0,1,2}. Head is output combinationally: `out_valid` = (`count`≠0).
- Pop: fires when `out_valid` && `out_ready`.
- Push: fires in FETCH when all of the following hold:
  - no `redirect`,
  - `pc` ≤ `IMEM_BYTES-4`,
  - `count`<2, or `count`==2 with a pop in the same cycle.
- On push: entry = {`pc`, `imem_data`} and `pc` ← `pc`+4, wrapping modulo 2^ADDR_WIDTH. Otherwise `pc` holds.
- Simultaneous push and pop: `count` is unchanged and order is preserved (FIFO).
- Out-of-range: in FETCH with `pc` > `IMEM_BYTES-4`:
  - no push; → HALT with `fault`=1 and `fault_addr`=`pc`.
  - Already-queued entries still drain normally.
- Redirect has highest priority below reset, in either state:
  - the queue is flushed (`count` ← 0); any same-cycle pop is accepted by decode but the entry is discarded;
  - no push occurs that cycle;
  - if `redirect_pc[1:0]`==0: `pc` ← `redirect_pc`, state ← FETCH, `fault` ← 0, `fault_addr` ← 0;
  - else: state ← HALT, `fault` ← 1, `fault_addr` ← `redirect_pc`, `pc` ← `redirect_pc`.
- A redirect to an aligned but out-of-range target is accepted, then faults on the next cycle via the out-of-range rule.
- `imem_data` is not registered before capture and the byte order is taken as delivered: the byte at `imem_addr` is bits [31:24].

## Timing
- Reset values (after `rst` sampled high at an edge):
  - `pc`=`imem_addr`=`RESET_PC`, `count`=0, state=FETCH
  - `out_valid`=0, `out_pc`=0, `out_instr`=0
  - `fault`=0, `fault_addr`=0
- `rst` mid-operation discards queue contents and clears any fault on that edge.
- First instruction: the edge after reset release pushes it, so `out_valid`=1 one cycle after `rst` falls.
- Redirect latency: redirect sampled at edge E. At E+1 the target instruction is pushed, so `out_valid`=1 after E+1. Entries that were valid before E are gone after E.
- Steady-state throughput: 1 instruction/cycle while `out_ready`=1.
- Stall: with `out_ready`=0, the queue fills in 2 cycles, then `pc` holds. Head outputs stay stable while `out_valid`=1 and `out_ready`=0.
- `fault` asserts on the edge the HALT transition is taken and stays high until a legal redirect or reset.

## Test plan
- Reset, then `out_ready`=1 and memory loaded with words W0..: `out_pc` = 0, 4, 8, … on consecutive cycles with `out_instr`=W(pc/4), and no bubbles after the first.
- Hold `out_ready`=0 for 5 cycles: `count` saturates at 2, `imem_addr` freezes at 8, and `out_pc`=0 is stable. Release: 0, 4, 8 are delivered in order with no loss or duplication.
- `redirect`=1 with `redirect_pc`=0x20 while 2 entries are queued and `out_ready`=1: after that edge `out_valid`=0; next cycle `out_pc`=0x20; the old entries never reappear.
- Sequential run to the end of the default 91-byte memory: the last pushed pc is 84 and the next, 88, faults. `fault`=1, `fault_addr`=88, `out_valid` drops after 84 drains; then `redirect` to 0x0 clears the fault and fetch resumes at 0.
- `redirect_pc`=0x1E: `fault`=1 and `fault_addr`=0x1E with no pushes; `rst` pulse → `fault`=0, `pc`=`RESET_PC`.
- `rst` asserted while `count`=2 and `redirect` asserted together: reset wins, so `count`=0 and `pc`=`RESET_PC`.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, captures imem words into a 2-entry {pc, instr} queue; head visible one cycle after push.
// Backpressure: out_ready low lets the queue fill to 2, then the PC holds; redirect flushes, bad PCs halt with fault.
module fetch_stage #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    IMEM_BYTES  = 91
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic                   fault,
    output logic [ADDR_WIDTH-1:0]  fault_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(IMEM_BYTES - 4);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [1:0]             count_q, count_d;
    logic [ADDR_WIDTH-1:0]  head_pc_q, head_pc_d;
    logic [INSTR_WIDTH-1:0] head_instr_q, head_instr_d;
    logic [ADDR_WIDTH-1:0]  tail_pc_q, tail_pc_d;
    logic [INSTR_WIDTH-1:0] tail_instr_q, tail_instr_d;
    logic                   fault_q, fault_d;
    logic [ADDR_WIDTH-1:0]  fault_addr_q, fault_addr_d;

    logic       pop;
    logic       push;
    logic       in_range;
    logic [1:0] remain;

    assign pop      = (count_q != 2'd0) && out_ready;
    assign in_range = (pc_q <= LAST_PC);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        count_d      = count_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        push         = 1'b0;
        remain       = count_q - {1'b0, pop};

        if (redirect) begin
            // Flush; a same-cycle pop is handshaken but its entry is dropped.
            count_d = 2'd0;
            pc_d    = redirect_pc;
            if (redirect_pc[1:0] == 2'b00) begin
                state_d      = ST_FETCH;
                fault_d      = 1'b0;
                fault_addr_d = '0;
            end else begin
                state_d      = ST_HALT;
                fault_d      = 1'b1;
                fault_addr_d = redirect_pc;
            end
        end else begin
            if (state_q == ST_FETCH) begin
                if (!in_range) begin
                    state_d      = ST_HALT;
                    fault_d      = 1'b1;
                    fault_addr_d = pc_q;
                end else if (remain != 2'd2) begin
                    push = 1'b1;
                end
            end

            if (pop) begin
                head_pc_d    = tail_pc_q;
                head_instr_d = tail_instr_q;
            end

            // Write slot is the occupancy left after this cycle's pop.
            if (push) begin
                if (remain == 2'd0) begin
                    head_pc_d    = pc_q;
                    head_instr_d = imem_data;
                end else begin
                    tail_pc_d    = pc_q;
                    tail_instr_d = imem_data;
                end
                pc_d = pc_q + PC_STEP;
            end

            count_d = remain + {1'b0, push};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            count_q      <= 2'd0;
            head_pc_q    <= '0;
            head_instr_q <= '0;
            tail_pc_q    <= '0;
            tail_instr_q <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            count_q      <= count_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // Stale head contents after a flush are masked so the outputs read 0 when empty.
    assign imem_addr  = pc_q;
    assign out_valid  = (count_q != 2'd0);
    assign out_pc     = out_valid ? head_pc_q : '0;
    assign out_instr  = out_valid ? head_instr_q : '0;
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, an end-of-memory run, then random traffic vs a queue model.
module tb_fetch_stage;

    localparam int MEM_BYTES = 91;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fault;
    logic [31:0] fault_addr;

    int checks = 0;
    int errors = 0;

    fetch_stage #(
        .ADDR_WIDTH (32),
        .INSTR_WIDTH(32),
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (MEM_BYTES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    always #5 clk = ~clk;

    // Memory contents are a fixed byte pattern; byte at the address lands in [31:24].
    function automatic logic [7:0] byte_at(input logic [31:0] a);
        if (a < MEM_BYTES) return 8'(a * 37 + 11);
        return 8'h00;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {byte_at(a), byte_at(a + 1), byte_at(a + 2), byte_at(a + 3)};
    endfunction

    assign imem_data = word_at(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic d, input logic [31:0] p, input logic y);
        rst         = r;
        redirect    = d;
        redirect_pc = p;
        out_ready   = y;
    endtask

    // Reference model: queue of fetched pairs plus PC / halt / fault state.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc    = '0;
    logic        m_halt  = 1'b0;
    logic        m_fault = 1'b0;
    logic [31:0] m_faddr = '0;

    task automatic model_step(input logic r, input logic d, input logic [31:0] p, input logic y);
        logic do_pop;
        if (r) begin
            mq.delete();
            m_pc = 32'h0; m_halt = 1'b0; m_fault = 1'b0; m_faddr = '0;
            return;
        end
        do_pop = (mq.size() > 0) && y;
        if (d) begin
            mq.delete();
            m_pc = p;
            if (p % 4 == 0) begin
                m_halt = 1'b0; m_fault = 1'b0; m_faddr = '0;
            end else begin
                m_halt = 1'b1; m_fault = 1'b1; m_faddr = p;
            end
            return;
        end
        if (do_pop) void'(mq.pop_front());
        if (!m_halt) begin
            if (m_pc > MEM_BYTES - 4) begin
                m_halt = 1'b1; m_fault = 1'b1; m_faddr = m_pc;
            end else if (mq.size() < 2) begin
                mq.push_back('{pc: m_pc, instr: word_at(m_pc)});
                m_pc = m_pc + 4;
            end
        end
    endtask

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_fault;
        logic [31:0] e_faddr;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vt[25];

    initial begin
        //            rst redir rpc       rdy  valid pc        fault faddr     addr
        vt[0]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00,  32'h00};
        vt[1]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00,  32'h04};
        vt[2]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00,  32'h08};
        vt[3]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00,  32'h0C};
        vt[4]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00,  32'h0C};
        vt[5]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00,  32'h0C};
        vt[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h08, 1'b0, 32'h00,  32'h10};
        vt[7]  = '{1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00,  32'h20};
        vt[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h20, 1'b0, 32'h00,  32'h24};
        vt[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h24, 1'b0, 32'h00,  32'h28};
        vt[10] = '{1'b0, 1'b1, 32'h1E, 1'b1, 1'b0, 32'h00, 1'b1, 32'h1E,  32'h1E};
        vt[11] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 32'h1E,  32'h1E};
        vt[12] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00,  32'h00};
        vt[13] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00,  32'h04};
        vt[14] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00,  32'h08};
        vt[15] = '{1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00,  32'h00};
        vt[16] = '{1'b0, 1'b1, 32'h54, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00,  32'h54};
        vt[17] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h54, 1'b0, 32'h00,  32'h58};
        vt[18] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h54, 1'b1, 32'h58,  32'h58};
        vt[19] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 32'h58,  32'h58};
        vt[20] = '{1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00,  32'h00};
        vt[21] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00,  32'h04};
        vt[22] = '{1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h100};
        vt[23] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 32'h100, 32'h100};
        vt[24] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00,  32'h00};

        // Directed vectors: inputs applied before an edge, outputs checked after it.
        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            drive(vt[i].rst, vt[i].redir, vt[i].rpc, vt[i].rdy);
            @(negedge clk);
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d out_pc", i), out_pc, vt[i].e_pc);
            chk($sformatf("vec%0d out_instr", i), out_instr,
                vt[i].e_valid ? word_at(vt[i].e_pc) : 32'h0);
            chk($sformatf("vec%0d fault", i), 32'(fault), 32'(vt[i].e_fault));
            chk($sformatf("vec%0d fault_addr", i), fault_addr, vt[i].e_faddr);
            chk($sformatf("vec%0d imem_addr", i), imem_addr, vt[i].e_addr);
        end

        // Full sequential run to the end of memory with no bubbles, then fault and recover.
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            chk($sformatf("seq%0d out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("seq%0d out_pc", k), out_pc, 32'(4 * k));
            chk($sformatf("seq%0d out_instr", k), out_instr, word_at(32'(4 * k)));
            chk($sformatf("seq%0d fault", k), 32'(fault), 32'd0);
        end
        @(negedge clk);
        chk("end fault", 32'(fault), 32'd1);
        chk("end fault_addr", fault_addr, 32'd88);
        chk("end out_valid", 32'(out_valid), 32'd0);
        drive(1'b0, 1'b1, 32'h0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("recover fault", 32'(fault), 32'd0);
        @(negedge clk);
        chk("recover out_valid", 32'(out_valid), 32'd1);
        chk("recover out_pc", out_pc, 32'h0);

        // Random traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            logic        r, d, y;
            logic [31:0] p;
            int          sel;
            r   = (c == 0) || ($urandom_range(0, 63) == 0);
            d   = ($urandom_range(0, 15) == 0);
            y   = ($urandom_range(0, 9) < 7);
            sel = $urandom_range(0, 9);
            if (sel < 7)       p = 32'($urandom_range(0, 21)) * 4;
            else if (sel == 7) p = 32'($urandom_range(22, 40)) * 4;
            else               p = 32'($urandom_range(0, 100)) * 4 + 32'($urandom_range(1, 3));
            drive(r, d, p, y);
            model_step(r, d, p, y);
            @(negedge clk);
            chk("rnd out_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("rnd out_pc", out_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
            chk("rnd out_instr", out_instr, (mq.size() > 0) ? mq[0].instr : 32'h0);
            chk("rnd fault", 32'(fault), 32'(m_fault));
            chk("rnd fault_addr", fault_addr, m_faddr);
            chk("rnd imem_addr", imem_addr, m_pc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
